branch_sequencer: RTL
=====================

# branch_sequencer

Control-unit FSM that generates the per-step datapath control strobes for conditional-branch instructions (brzr/brnz/brpl/brmi). It replaces hand-timed testbench sequencing of the T0–T6 steps. It drives the Datapath control inputs directly and adds four capabilities: parametrised step dwell, a memory-ready handshake with timeout, a PC load gated by the CON flip-flop, and done/error status.

## Interface
- `STEP_CYCLES`, default 1: cycles each T-state is held (≥1).
- `MEM_TIMEOUT`, default 16: maximum cycles in T1 waiting for `mem_ready`; 0 disables the timeout.
- `OPW`, default 5: ALU opcode width.
- `ADD_OP`, default 5'b00011: ALU opcode driven in T5.
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `clr`  in  1  synchronous active-high reset.
- `start`  in  1  begin one branch sequence; sampled only in IDLE.
- `mem_ready`  in  1  RAM read data valid on Mdatain.
- `con_ff`  in  1  CON flip-flop output from the datapath.
- `PC_out`, `MAR_enable`, `IncPC`, `PC_enable`, `Read`, `MDR_enable`, `MDR_out`, `IR_enable`, `Gra`, `R_out`, `con_in`, `Y_enable`, `C_out`, `Z_enable`, `ZLow_out`  out  1 each  datapath strobes.
- `opcode`  out  OPW  ALU operation select.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse at normal completion.
- `err`  out  1  one-cycle pulse on memory timeout.
- `taken`  out  1  latched branch decision, held until the next start.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6. Strobes are Moore outputs decoded from the registered state, so there are no combinational paths from inputs to strobes.
- Strobes asserted per state (all other strobes are 0):
  - T0: PC_out, MAR_enable, IncPC, PC_enable.
  - T1: Read, MDR_enable.
  - T2: MDR_out, IR_enable.
  - T3: Gra, R_out, con_in.
  - T4: PC_out, Y_enable.
  - T5: C_out, Z_enable, with `opcode`=ADD_OP. In every other state `opcode` is 0.
  - T6: ZLow_out, with PC_enable = `taken`.
- Each state holds for STEP_CYCLES cycles, counted by the dwell counter, which clears on every state change.
- T1 exits only when the dwell count is complete and `mem_ready`=1 in the same cycle.
- `taken` loads from `con_ff` on the first cycle of T4, which is the cycle after the CON flip-flop captured in T3. `taken` clears on an accepted start.
- On the last cycle of T6 the FSM goes to IDLE, and `done` is 1 in the first IDLE cycle.
- Timeout: with MEM_TIMEOUT=M>0, if T1 has run M cycles without exiting, the FSM goes to IDLE, `err` pulses in that first IDLE cycle, and no further strobes are issued. `taken` keeps its previous value.
- `start` is ignored while `busy`=1. A start in the `done`/`err` cycle is accepted.
- `clr` is synchronous and overrides everything, including mid-sequence: the next state is IDLE, all outputs are 0, and the counters are 0.

## Timing
- Reset values: state IDLE, every strobe 0, `opcode` 0, `busy` 0, `done` 0, `err` 0, `taken` 0.
- Start latency: `start` high in IDLE at edge k puts the FSM in T0 in cycle k+1.
- Sequence length: with STEP_CYCLES=N and `mem_ready` already high, the sequence occupies 7·N cycles, and `done` appears at cycle 7·N+1 after the start edge.
- T1 stretch: T1 lasts max(N, first cycle with `mem_ready` sampled high).
- The dwell and timeout counters are wide enough that they never wrap for legal parameters.

## Structure
- Package `branch_seq_pkg` holds:
  - the state encoding, 4-bit, with IDLE=0 and T0..T6=1..7;
  - ALU opcode constants (ADD=5'b00011);
  - C2 condition encodings (00 zero, 01 nonzero, 10 positive, 11 negative) for shared use with the CON logic.
- One sub-module, `step_timer`: a loadable/clearable up-counter with a `terminal` output, instantiated once for dwell and once for timeout.

## Test plan
- STEP_CYCLES=1, `mem_ready`=1, `con_ff`=1: one start → the strobe pattern above over 7 cycles, PC_enable=1 in T6, `done` at cycle 8, `taken`=1.
- Same setup with `con_ff`=0 → T6 asserts ZLow_out only with PC_enable=0, and `taken`=0.
- STEP_CYCLES=3, `mem_ready` rising on the 5th cycle of T1 → T1 lasts 5 cycles, total 23 cycles to `done`.
- MEM_TIMEOUT=4, `mem_ready`=0 → 4 cycles of Read/MDR_enable, then `err` pulse, IDLE, and no T2 strobes.
- `clr` asserted during T3 → the next cycle is IDLE with all outputs 0. A subsequent start runs cleanly.
- `start` held high through a whole sequence → a second sequence begins in the cycle after `done`. No start is accepted while `busy`=1.

Source files
------------

// File: rtl/branch_seq_pkg.sv
// Shared encodings for the branch-instruction control sequencer and the CON logic.
// Holds the FSM state encoding, ALU opcodes, C2 condition codes and a counter-width helper.
package branch_seq_pkg;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        T0   = 4'd1,
        T1   = 4'd2,
        T2   = 4'd3,
        T3   = 4'd4,
        T4   = 4'd5,
        T5   = 4'd6,
        T6   = 4'd7
    } state_t;

    localparam logic [4:0] ALU_ADD = 5'b00011;

    // C2 field of a branch instruction, as decoded by the CON flip-flop logic
    typedef enum logic [1:0] {
        C2_ZERO    = 2'b00,
        C2_NONZERO = 2'b01,
        C2_POS     = 2'b10,
        C2_NEG     = 2'b11
    } cond_t;

    // Bits needed to count 0..max_count-1 without wrapping
    function automatic int cnt_w(input int max_count);
        return (max_count < 2) ? 1 : $clog2(max_count);
    endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable/clearable saturating up-counter; terminal is high once count reaches limit.
module step_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count,
    output logic         terminal
);

    assign terminal = (count == limit);

    // Holds at the limit so a stretched state keeps reporting terminal
    always_ff @(posedge clk) begin
        if (clr || clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && !terminal) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/branch_sequencer.sv
// Control FSM generating T0..T6 datapath strobes for brzr/brnz/brpl/brmi, with
// per-step dwell, memory-ready handshake and timeout, CON-gated PC load and status pulses.
module branch_sequencer
    import branch_seq_pkg::*;
#(
    parameter int             STEP_CYCLES = 1,
    parameter int             MEM_TIMEOUT = 16,
    parameter int             OPW         = 5,
    parameter logic [OPW-1:0] ADD_OP      = OPW'(ALU_ADD)
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           start,
    input  logic           mem_ready,
    input  logic           con_ff,
    output logic           PC_out,
    output logic           MAR_enable,
    output logic           IncPC,
    output logic           PC_enable,
    output logic           Read,
    output logic           MDR_enable,
    output logic           MDR_out,
    output logic           IR_enable,
    output logic           Gra,
    output logic           R_out,
    output logic           con_in,
    output logic           Y_enable,
    output logic           C_out,
    output logic           Z_enable,
    output logic           ZLow_out,
    output logic [OPW-1:0] opcode,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic           taken
);

    localparam int DWELL_W = cnt_w(STEP_CYCLES);
    localparam int TO_W    = cnt_w(MEM_TIMEOUT);

    state_t               state, state_nxt;
    logic                 state_chg;
    logic                 done_nxt, err_nxt;
    logic [DWELL_W-1:0]   dwell_cnt;
    logic                 dwell_term;
    logic [TO_W-1:0]      to_cnt_unused;
    logic                 to_term;

    step_timer #(.W(DWELL_W)) u_dwell (
        .clk        (clk),
        .clr        (clr),
        .clear      (state_chg),
        .load       (1'b0),
        .load_value ('0),
        .enable     (1'b1),
        .limit      (DWELL_W'(STEP_CYCLES - 1)),
        .count      (dwell_cnt),
        .terminal   (dwell_term)
    );

    step_timer #(.W(TO_W)) u_timeout (
        .clk        (clk),
        .clr        (clr),
        .clear      (state_chg || (state != T1)),
        .load       (1'b0),
        .load_value ('0),
        .enable     (state == T1),
        .limit      (TO_W'(MEM_TIMEOUT - 1)),
        .count      (to_cnt_unused),
        .terminal   (to_term)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            done  <= 1'b0;
            err   <= 1'b0;
            taken <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
            // CON was captured in T3, so it is stable on the first T4 cycle
            if (state == IDLE && start) begin
                taken <= 1'b0;
            end else if (state == T4 && dwell_cnt == '0) begin
                taken <= con_ff;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = T0;
            T0:   if (dwell_term) state_nxt = T1;
            T1: begin
                if (dwell_term && mem_ready) begin
                    state_nxt = T2;
                end else if (MEM_TIMEOUT > 0 && to_term) begin
                    state_nxt = IDLE;
                    err_nxt   = 1'b1;
                end
            end
            T2:   if (dwell_term) state_nxt = T3;
            T3:   if (dwell_term) state_nxt = T4;
            T4:   if (dwell_term) state_nxt = T5;
            T5:   if (dwell_term) state_nxt = T6;
            T6: begin
                if (dwell_term) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        state_chg = (state_nxt != state);
    end

    always_comb begin
        PC_out     = 1'b0;
        MAR_enable = 1'b0;
        IncPC      = 1'b0;
        PC_enable  = 1'b0;
        Read       = 1'b0;
        MDR_enable = 1'b0;
        MDR_out    = 1'b0;
        IR_enable  = 1'b0;
        Gra        = 1'b0;
        R_out      = 1'b0;
        con_in     = 1'b0;
        Y_enable   = 1'b0;
        C_out      = 1'b0;
        Z_enable   = 1'b0;
        ZLow_out   = 1'b0;
        opcode     = '0;
        busy       = (state != IDLE);
        case (state)
            T0: begin
                PC_out     = 1'b1;
                MAR_enable = 1'b1;
                IncPC      = 1'b1;
                PC_enable  = 1'b1;
            end
            T1: begin
                Read       = 1'b1;
                MDR_enable = 1'b1;
            end
            T2: begin
                MDR_out    = 1'b1;
                IR_enable  = 1'b1;
            end
            T3: begin
                Gra        = 1'b1;
                R_out      = 1'b1;
                con_in     = 1'b1;
            end
            T4: begin
                PC_out     = 1'b1;
                Y_enable   = 1'b1;
            end
            T5: begin
                C_out      = 1'b1;
                Z_enable   = 1'b1;
                opcode     = ADD_OP;
            end
            T6: begin
                ZLow_out   = 1'b1;
                PC_enable  = taken;
            end
            default: ;
        endcase
    end

endmodule
